// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Brief    : Sequences one load / N-shift / capture transfer on a serial-
//            parallel shift register that samples its controls on negedge.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             ready,
    input  logic             abort,
    input  logic             dir,
    input  logic [CW-1:0]    nbits,
    input  logic [WIDTH-1:0] txdata,
    input  logic             ser_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rxdata,
    output logic             sh_pload,
    output logic             sh_enable,
    output logic             sh_leftright,
    output logic             sh_serialin,
    output logic [WIDTH-1:0] sh_pdatain,
    input  logic [WIDTH-1:0] sh_pdataout
);

    localparam logic [CW-1:0] c_WIDTH_CW = CW'(WIDTH);
    localparam logic [CW-1:0] c_ONE      = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_SHIFT   = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      r_n;
    logic               r_busy;
    logic               r_done;
    logic               r_pload;
    logic               r_enable;
    logic               r_lr;
    logic [WIDTH-1:0]   r_pd;
    logic [WIDTH-1:0]   r_rx;

    logic [CW-1:0]      w_n_eff;
    logic               w_last;

    // Zero or out-of-range counts mean a full-width transfer.
    always_comb begin
        w_n_eff = nbits;
        if ((nbits == '0) || (nbits > c_WIDTH_CW)) begin
            w_n_eff = c_WIDTH_CW;
        end
    end

    assign w_last = (r_cnt == (r_n - c_ONE));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_n      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pload  <= 1'b0;
            r_enable <= 1'b0;
            r_lr     <= 1'b0;
            r_pd     <= '0;
            r_rx     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_n     <= w_n_eff;
                        r_lr    <= dir;
                        r_pd    <= txdata;
                        r_pload <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_pload <= 1'b0;
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state  <= S_SHIFT;
                        r_enable <= 1'b1;
                        r_cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        r_state  <= S_IDLE;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (w_last) begin
                        r_state  <= S_CAPTURE;
                        r_enable <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
                S_CAPTURE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    // Aborting here still suppresses both the capture and done.
                    if (!abort) begin
                        r_rx   <= sh_pdataout;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_pload  <= 1'b0;
                    r_enable <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign ready        = ~r_busy;
    assign done         = r_done;
    assign rxdata       = r_rx;
    assign sh_pload     = r_pload;
    assign sh_enable    = r_enable;
    assign sh_leftright = r_lr;
    assign sh_pdatain   = r_pd;
    assign sh_serialin  = ser_in;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Brief    : Directed bench for shift_sequencer with a negedge shifter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dir   = 1'b0;
    logic [2:0] nbits = '0;
    logic [3:0] txdata = '0;
    logic       ser_in = 1'b0;
    logic       ready, busy, done;
    logic [3:0] rxdata;
    logic       sh_pload, sh_enable, sh_leftright, sh_serialin;
    logic [3:0] sh_pdatain, sh_pdataout;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.WIDTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .ready        (ready),
        .abort        (abort),
        .dir          (dir),
        .nbits        (nbits),
        .txdata       (txdata),
        .ser_in       (ser_in),
        .busy         (busy),
        .done         (done),
        .rxdata       (rxdata),
        .sh_pload     (sh_pload),
        .sh_enable    (sh_enable),
        .sh_leftright (sh_leftright),
        .sh_serialin  (sh_serialin),
        .sh_pdatain   (sh_pdatain),
        .sh_pdataout  (sh_pdataout)
    );

    always #5 clock = ~clock;

    // Behavioural 4-bit shifter sharing the async reset, sampling on negedge.
    logic [3:0] q = '0;
    always @(negedge clock or negedge reset) begin
        if (!reset)          q <= '0;
        else if (sh_pload)   q <= sh_pdatain;
        else if (sh_enable)  q <= sh_leftright ? {q[2:0], sh_serialin} : {sh_serialin, q[3:1]};
    end
    assign sh_pdataout = q;

    int         en_total = 0;
    int         left_total = 0;
    logic [3:0] so_hist = '0;
    logic       overlap = 1'b0;
    always @(negedge clock) begin
        if (sh_enable) begin
            en_total <= en_total + 1;
            so_hist  <= {so_hist[2:0], q[3]};
            if (sh_leftright) left_total <= left_total + 1;
        end
        if (sh_pload && sh_enable) overlap <= 1'b1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input string tag, input logic d, input logic [2:0] nb,
                            input logic [3:0] tx, input logic si,
                            input logic [3:0] exp_rx, input int exp_n);
        int k;
        int base;
        base   = en_total;
        dir    = d;
        nbits  = nb;
        txdata = tx;
        ser_in = si;
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_pload"}, sh_pload, 1);
        chk({tag, "_busy"}, {busy, ready}, 2'b10);
        k = 0;
        while (!done && k < 30) begin
            tick();
            k++;
        end
        chk({tag, "_latency"}, k, exp_n + 2);
        chk({tag, "_rxdata"}, rxdata, exp_rx);
        chk({tag, "_enables"}, en_total - base, exp_n);
        chk({tag, "_ready"}, ready, 1);
        tick();
        chk({tag, "_donepulse"}, done, 0);
    endtask

    initial begin
        int k;
        int base;
        int lbase;
        logic seen;

        #3;
        chk("reset_state", {busy, ready, done, sh_pload, sh_enable, sh_leftright}, 6'b010000);
        chk("reset_data", {rxdata, sh_pdatain}, 8'h00);
        #9;
        reset = 1'b1;
        tick();

        run_xfer("full_left", 1'b1, 3'd4, 4'b1011, 1'b0, 4'b0000, 4);
        chk("full_left_serialout", so_hist, 4'b1011);

        run_xfer("partial_left", 1'b1, 3'd2, 4'b1011, 1'b1, 4'b1111, 2);

        lbase = left_total;
        run_xfer("right_one", 1'b0, 3'd1, 4'b1011, 1'b0, 4'b0101, 1);
        chk("right_one_lr", {sh_leftright, 32'(left_total - lbase)}, 33'd0);

        run_xfer("nbits0", 1'b0, 3'd0, 4'b1011, 1'b1, 4'b1111, 4);
        run_xfer("nbits7", 1'b1, 3'd7, 4'b0110, 1'b1, 4'b1111, 4);

        // Start pulsed mid-SHIFT must be dropped.
        base   = en_total;
        dir    = 1'b0;
        nbits  = 3'd2;
        txdata = 4'b1100;
        ser_in = 1'b0;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start  = 1'b1;
        txdata = 4'b1111;
        nbits  = 3'd1;
        chk("busy_start_ready", ready, 0);
        tick();
        start = 1'b0;
        k = 2;
        while (!done && k < 30) begin
            tick();
            k++;
        end
        chk("busy_start_latency", k, 4);
        chk("busy_start_rxdata", rxdata, 4'b0011);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy || done) seen = 1'b1;
        end
        chk("busy_start_nosecond", seen, 0);
        chk("busy_start_enables", en_total - base, 2);

        // Abort during the second SHIFT cycle.
        base   = en_total;
        dir    = 1'b1;
        nbits  = 3'd4;
        txdata = 4'b1111;
        ser_in = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ctrl", {sh_enable, sh_pload, busy, ready}, 4'b0001);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("abort_nodone", seen, 0);
        chk("abort_rxdata", rxdata, 4'b0011);
        chk("abort_enables", en_total - base, 2);

        // Asynchronous reset in the middle of SHIFT.
        dir    = 1'b1;
        nbits  = 3'd4;
        txdata = 4'b1010;
        ser_in = 1'b1;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_ctrl", {busy, ready, done, sh_pload, sh_enable, sh_leftright}, 6'b010000);
        chk("midreset_data", {rxdata, sh_pdatain, sh_pdataout}, 12'h000);
        #2;
        reset = 1'b1;
        tick();
        run_xfer("after_reset", 1'b1, 3'd4, 4'b0110, 1'b0, 4'b0000, 4);

        chk("no_overlap", overlap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
